clk_div_sequencer: RTL and testbench

Run-time controller for the lab clock generator path. Owns a programmable divide ratio, accepts new ratios over a valid/ready handshake, and applies them only at a period boundary so the divided output never produces a runt pulse. Outputs a registered divided clock, a period-start strobe and a rising-edge toggle counter for board/bench observation.

---
 rtl/clk_div_sequencer.sv | 122 ++++++++++++
 tb/tb_clk_div_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clk_div_sequencer.sv
// clk_div_sequencer: programmable clock divider with glitch-free ratio changes at period boundaries
module clk_div_sequencer #(
    parameter int CNT_W       = 8,
    parameter int TOG_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             strobe,
    output logic [TOG_W-1:0] toggle_counter,
    output logic [CNT_W-1:0] active_div
);

    typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_pending;
    logic             r_clk_div;
    logic             r_strobe;
    logic             r_cfg_err;
    logic [TOG_W-1:0] r_tog;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_active_nxt;
    logic [CNT_W-1:0] w_pending_nxt;
    logic             w_xfer;
    logic             w_legal;
    logic             w_wrap;
    logic             w_running_nxt;
    logic             w_clk_nxt;

    assign cfg_ready      = r_state != PEND;
    assign cfg_err        = r_cfg_err;
    assign clk_div        = r_clk_div;
    assign strobe         = r_strobe;
    assign toggle_counter = r_tog;
    assign active_div     = r_active;

    assign w_xfer        = cfg_valid & cfg_ready;
    assign w_legal       = cfg_div >= CNT_W'(2);
    assign w_wrap        = r_cnt == r_active - CNT_W'(1);
    assign w_running_nxt = w_state_nxt != STOP;
    assign w_clk_nxt     = w_running_nxt && (w_cnt_nxt < (w_active_nxt >> 1));

    // next state, period counter and ratio bookkeeping; ratio only changes with cnt returning to 0
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        case (r_state)
            STOP: begin
                w_cnt_nxt = '0;
                if (w_xfer && w_legal) w_active_nxt = cfg_div;
                if (run) w_state_nxt = RUN;
            end
            RUN: begin
                if (!run) begin
                    w_state_nxt = STOP;
                    w_cnt_nxt   = '0;
                    if (w_xfer && w_legal) w_active_nxt = cfg_div;
                end else begin
                    w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
                    if (w_xfer && w_legal) begin
                        w_pending_nxt = cfg_div;
                        w_state_nxt   = PEND;
                    end
                end
            end
            PEND: begin
                if (!run) begin
                    w_state_nxt  = STOP;
                    w_cnt_nxt    = '0;
                    w_active_nxt = r_pending;
                end else if (w_wrap) begin
                    w_state_nxt  = RUN;
                    w_cnt_nxt    = '0;
                    w_active_nxt = r_pending;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = STOP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // state and registered outputs; clk_div is derived from the next cnt/ratio so it stays aligned with cnt
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= STOP;
            r_cnt     <= '0;
            r_active  <= CNT_W'(DEFAULT_DIV);
            r_pending <= '0;
            r_clk_div <= 1'b0;
            r_strobe  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_tog     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_clk_div <= w_clk_nxt;
            r_strobe  <= w_running_nxt && (w_cnt_nxt == '0);
            r_cfg_err <= w_xfer & ~w_legal;
            if (w_clk_nxt && !r_clk_div) r_tog <= r_tog + TOG_W'(1);
        end
    end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// tb_clk_div_sequencer: scoreboard bench comparing the divider against a period-position reference model
module tb_clk_div_sequencer;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] cfg_div = '0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_div;
    logic       strobe;
    logic [7:0] toggle_counter;
    logic [7:0] active_div;

    clk_div_sequencer #(.CNT_W(8), .TOG_W(8), .DEFAULT_DIV(2)) dut (
        .clk_in(clk_in), .rst(rst), .run(run), .cfg_div(cfg_div), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_div(clk_div), .strobe(strobe),
        .toggle_counter(toggle_counter), .active_div(active_div)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit clk;
        bit stb;
        bit err;
        bit rdy;
        int tog;
        int act;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    bit m_running = 0;
    int m_pos = 0;
    int m_ratio = 2;
    bit m_has_pend = 0;
    int m_pend = 0;
    int m_tog = 0;
    bit m_prev_clk = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference: the block is "running at position pos within a period of length ratio"
    task automatic model_step(input bit r, input bit go, input bit v, input int d);
        exp_t e;
        bit xfer;
        bit ok;
        bit err;
        bit c;
        xfer = v && !m_has_pend;
        ok = d >= 2;
        err = 0;
        if (r) begin
            m_running = 0; m_pos = 0; m_ratio = 2; m_has_pend = 0; m_tog = 0; m_prev_clk = 0;
        end else begin
            err = xfer && !ok;
            if (!m_running) begin
                if (xfer && ok) m_ratio = d;
                if (go) begin m_running = 1; m_pos = 0; end
            end else if (!go) begin
                m_running = 0; m_pos = 0;
                if (m_has_pend) begin m_ratio = m_pend; m_has_pend = 0; end
                else if (xfer && ok) m_ratio = d;
            end else begin
                if (m_pos == m_ratio - 1) begin
                    m_pos = 0;
                    if (m_has_pend) begin m_ratio = m_pend; m_has_pend = 0; end
                end else m_pos++;
                if (xfer && ok) begin m_has_pend = 1; m_pend = d; end
            end
        end
        c = m_running && (m_pos < m_ratio / 2);
        if (c && !m_prev_clk) m_tog = (m_tog + 1) % 256;
        m_prev_clk = c;
        e.clk = c;
        e.stb = m_running && m_pos == 0;
        e.err = err;
        e.rdy = !m_has_pend;
        e.tog = m_tog;
        e.act = m_ratio;
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit go, input bit v, input int d);
        @(negedge clk_in);
        rst = r; run = go; cfg_valid = v; cfg_div = d[7:0];
        model_step(r, go, v, d);
    endtask

    // monitor: every cycle the block presents a full output set; compare it with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("clk_div", int'(clk_div), int'(e.clk));
                chk("strobe", int'(strobe), int'(e.stb));
                chk("cfg_err", int'(cfg_err), int'(e.err));
                chk("cfg_ready", int'(cfg_ready), int'(e.rdy));
                chk("toggle_counter", int'(toggle_counter), e.tog);
                chk("active_div", int'(active_div), e.act);
            end
        end
    end

    initial begin
        repeat (2) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (8) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 5);
        repeat (16) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 3);
        repeat (4) cyc(0, 1, 0, 0);
        for (int k = 0; k < 10 && !(m_running && m_pos == m_ratio - 1); k++) cyc(0, 1, 0, 0);
        chk("reach_wrap_n3", int'(m_running && m_pos == m_ratio - 1), 1);
        cyc(0, 1, 1, 4);
        repeat (14) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 6);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        repeat (20) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 2);
        repeat (520) cyc(0, 1, 0, 0);
        for (int k = 0; k < 4 && !m_prev_clk; k++) cyc(0, 1, 0, 0);
        chk("reach_high", int'(m_prev_clk), 1);
        cyc(1, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        for (int i = 0; i < 2500; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
                $urandom_range(0, 4) == 0, int'($urandom_range(0, 9)));
        repeat (2) @(negedge clk_in);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
